instr_queue: RTL

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_pkg.sv | 9 +
 rtl/instr_queue_if.sv | 19 +
 rtl/instr_queue.sv | 50 +++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// instr_queue_pkg: shared processor types and sizes for the instruction queue.
package instr_queue_pkg;
    localparam int XLEN = 32;
    localparam int IQ_DEPTH = 8;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } iq_entry_t;
endpackage

// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch-push and issue-pop handshake bundle of the instruction queue.
interface instr_queue_if #(parameter int XLEN = instr_queue_pkg::XLEN);
    logic            push_valid;
    logic [XLEN-1:0] push_instr;
    logic [XLEN-1:0] push_pc;
    logic            push_ready;
    logic            issue_ready;
    logic            head_valid;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;
    modport slave (
        input  push_valid, push_instr, push_pc, issue_ready,
        output push_ready, head_valid, head_instr, head_pc
    );
    modport master (
        output push_valid, push_instr, push_pc, issue_ready,
        input  push_ready, head_valid, head_instr, head_pc
    );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: show-ahead circular instruction queue between fetch and decode/issue.
module instr_queue #(
    parameter int DEPTH = instr_queue_pkg::IQ_DEPTH,
    parameter int XLEN = instr_queue_pkg::XLEN,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    instr_queue_if.slave         q,
    output logic [PW:0]          count,
    output logic                 full,
    output logic                 empty
);
    import instr_queue_pkg::*;
    iq_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           push_acc, pop_acc, wr_en;
    always_comb begin
        full     = count_q == (PW+1)'(DEPTH);
        empty    = count_q == '0;
        push_acc = q.push_valid && !full;
        pop_acc  = q.issue_ready && !empty;
        wr_en    = push_acc && !flush;
        wr_ptr_d = flush ? '0 : push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = flush ? '0 : count_q + (PW+1)'(push_acc) - (PW+1)'(pop_acc);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
    // storage is left unreset; validity is tracked solely by the pointers and count
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= '{instr: q.push_instr, pc: q.push_pc};
    end
    assign count        = count_q;
    assign q.push_ready = !full;
    assign q.head_valid = !empty;
    assign q.head_instr = empty ? '0 : mem_q[rd_ptr_q].instr;
    assign q.head_pc    = empty ? '0 : mem_q[rd_ptr_q].pc;
endmodule
